// File: rtl/dotp_da_pkg.sv
// Shared types and width helpers for the distributed-arithmetic dot-product controller.
package dotp_da_pkg;

    typedef enum logic [2:0] {
        EMPTY,
        FILL,
        IDLE,
        COMPUTE,
        OUT
    } state_t;

    function automatic int lut_width(input int n_taps, input int coef_width);
        return coef_width + $clog2(n_taps);
    endfunction

    function automatic int acc_width(input int n_taps, input int coef_width, input int x_width);
        return lut_width(n_taps, coef_width) + x_width;
    endfunction

endpackage

// File: rtl/da_dotp_controller_subset_sum.sv
// Subset sum of signed coefficients selected by the set bits of addr.
// Purely combinational, no backpressure.
module da_subset_sum
    import dotp_da_pkg::*;
#(
    parameter int N_TAPS     = 4,
    parameter int COEF_WIDTH = 8,
    parameter int LUT_WIDTH  = lut_width(N_TAPS, COEF_WIDTH)
) (
    input  logic [N_TAPS*COEF_WIDTH-1:0] coef,
    input  logic [N_TAPS-1:0]            addr,
    output logic signed [LUT_WIDTH-1:0]  sum
);

    always_comb begin
        sum = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            if (addr[i]) begin
                sum = sum + LUT_WIDTH'(signed'(coef[i*COEF_WIDTH +: COEF_WIDTH]));
            end
        end
    end

endmodule

// File: rtl/da_dotp_controller.sv
// DA dot-product sequencer: fills an external LUT with coefficient subset sums, then shift-accumulates.
// Latency: x handshake at cycle t -> y_valid at t+X_WIDTH+1; y_valid/y_out held until y_ready.
// Optional DA_DONE_CNT_EN adds a 16-bit completed-result counter on done_cnt.
module da_dotp_controller
    import dotp_da_pkg::*;
#(
    parameter int N_TAPS     = 4,
    parameter int COEF_WIDTH = 8,
    parameter int X_WIDTH    = 8,
    localparam int LUT_WIDTH = lut_width(N_TAPS, COEF_WIDTH),
    localparam int ACC_WIDTH = acc_width(N_TAPS, COEF_WIDTH, X_WIDTH)
) (
    input  logic                         clk,
    input  logic                         Reset,
    input  logic                         coef_load,
    input  logic [N_TAPS*COEF_WIDTH-1:0] coef_in,
    input  logic                         x_valid,
    output logic                         x_ready,
    input  logic [N_TAPS*X_WIDTH-1:0]    x_in,
    output logic                         y_valid,
    input  logic                         y_ready,
    output logic signed [ACC_WIDTH-1:0]  y_out,
    output logic                         busy,
    output logic [N_TAPS-1:0]            lut_addr,
    output logic signed [LUT_WIDTH-1:0]  lut_din,
    output logic                         lut_we,
    input  logic signed [LUT_WIDTH-1:0]  lut_dout,
    output logic [15:0]                  done_cnt
);

    localparam int KW = (X_WIDTH > 1) ? $clog2(X_WIDTH) : 1;

    state_t                        state;
    logic [N_TAPS*COEF_WIDTH-1:0]  coef_q;
    logic [N_TAPS*X_WIDTH-1:0]     x_q;
    logic [KW-1:0]                 k;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [ACC_WIDTH-1:0]   acc_next;
    logic signed [ACC_WIDTH-1:0]   lut_ext;
    logic signed [LUT_WIDTH-1:0]   fill_sum;

    function automatic logic [N_TAPS-1:0] bit_slice(input logic [N_TAPS*X_WIDTH-1:0] v, input int b);
        logic [N_TAPS-1:0] s;
        s = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            s[i] = v[i*X_WIDTH + b];
        end
        return s;
    endfunction

    // lut_din is registered, so the adder looks one address ahead of lut_addr.
    da_subset_sum #(
        .N_TAPS    (N_TAPS),
        .COEF_WIDTH(COEF_WIDTH),
        .LUT_WIDTH (LUT_WIDTH)
    ) u_subset_sum (
        .coef(coef_q),
        .addr(lut_addr + N_TAPS'(1)),
        .sum (fill_sum)
    );

    assign x_ready = (state == IDLE) && !coef_load;

    always_comb begin
        lut_ext  = ACC_WIDTH'(lut_dout);
        acc_next = (acc <<< 1) + lut_ext;
        if (k == KW'(X_WIDTH-1)) begin
            acc_next = -lut_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state    <= EMPTY;
            busy     <= 1'b0;
            lut_we   <= 1'b0;
            lut_addr <= '0;
            lut_din  <= '0;
            y_valid  <= 1'b0;
            y_out    <= '0;
            acc      <= '0;
            k        <= '0;
            coef_q   <= '0;
            x_q      <= '0;
        end else begin
            case (state)
                EMPTY, IDLE: begin
                    if (coef_load) begin
                        coef_q   <= coef_in;
                        state    <= FILL;
                        busy     <= 1'b1;
                        lut_we   <= 1'b1;
                        lut_addr <= '0;
                        lut_din  <= '0;
                    end else if (x_valid && state == IDLE) begin
                        x_q      <= x_in;
                        state    <= COMPUTE;
                        busy     <= 1'b1;
                        k        <= KW'(X_WIDTH-1);
                        lut_addr <= bit_slice(x_in, X_WIDTH-1);
                    end
                end
                FILL: begin
                    if (lut_addr == '1) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        lut_we   <= 1'b0;
                        lut_addr <= '0;
                        lut_din  <= '0;
                    end else begin
                        lut_addr <= lut_addr + N_TAPS'(1);
                        lut_din  <= fill_sum;
                    end
                end
                COMPUTE: begin
                    acc <= acc_next;
                    if (k == '0) begin
                        state    <= OUT;
                        y_valid  <= 1'b1;
                        y_out    <= acc_next;
                        lut_addr <= '0;
                    end else begin
                        k        <= k - KW'(1);
                        lut_addr <= bit_slice(x_q, int'(k) - 1);
                    end
                end
                OUT: begin
                    if (y_ready) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        y_valid <= 1'b0;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef DA_DONE_CNT_EN
    logic [15:0] done_q;

    always_ff @(posedge clk) begin
        if (Reset) begin
            done_q <= '0;
        end else if (y_valid && y_ready) begin
            done_q <= done_q + 16'd1;
        end
    end

    assign done_cnt = done_q;
`else
    assign done_cnt = '0;
`endif

endmodule

// File: tb/tb_da_dotp_controller.sv
// Directed bench for da_dotp_controller with a behavioural async-read LUT RAM beside it.
module tb_da_dotp_controller;

    logic               clk = 1'b0;
    logic               Reset;
    logic               coef_load;
    logic [31:0]        coef_in;
    logic               x_valid;
    logic               x_ready;
    logic [31:0]        x_in;
    logic               y_valid;
    logic               y_ready;
    logic signed [17:0] y_out;
    logic               busy;
    logic [3:0]         lut_addr;
    logic signed [9:0]  lut_din;
    logic               lut_we;
    logic signed [9:0]  lut_dout;
    logic [15:0]        done_cnt;

    logic signed [9:0]  ram [16];

    int     checks = 0;
    int     errors = 0;
    longint done_model = 0;

    typedef struct {
        logic [31:0] coef;
        logic [31:0] x;
        longint      y;
        string       nm;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    da_dotp_controller dut (
        .clk      (clk),
        .Reset    (Reset),
        .coef_load(coef_load),
        .coef_in  (coef_in),
        .x_valid  (x_valid),
        .x_ready  (x_ready),
        .x_in     (x_in),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .y_out    (y_out),
        .busy     (busy),
        .lut_addr (lut_addr),
        .lut_din  (lut_din),
        .lut_we   (lut_we),
        .lut_dout (lut_dout),
        .done_cnt (done_cnt)
    );

    always @(posedge clk) begin
        if (lut_we) ram[lut_addr] <= lut_din;
    end
    assign lut_dout = ram[lut_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint subset(input logic [31:0] c, input int a);
        longint s = 0;
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = c[i*8 +: 8];
            if (a[i]) s += longint'($signed(b));
        end
        return s;
    endfunction

    task automatic load_coef(input logic [31:0] c, input string nm);
        int n = 0;
        coef_in = c;
        coef_load = 1'b1;
        step();
        coef_load = 1'b0;
        while (!x_ready && n < 40) begin
            step();
            n++;
        end
        check({nm, "_fill_len"}, n, 16);
        check({nm, "_fill_rdy"}, x_ready, 1);
    endtask

    task automatic send_x(input logic [31:0] x, input longint exp_y, input string nm, input int inject);
        int lat;
        x_in = x;
        x_valid = 1'b1;
        step();
        x_valid = 1'b0;
        lat = 1;
        while (!y_valid && lat < 30) begin
            coef_load = (lat == inject);
            step();
            coef_load = 1'b0;
            if (inject != 0 && lat == inject) check({nm, "_ignored_we"}, lut_we, 0);
            lat++;
        end
        check({nm, "_latency"}, lat, 9);
        check({nm, "_y"}, y_out, exp_y);
    endtask

    task automatic finish_out(input string nm);
        y_ready = 1'b1;
        step();
`ifdef DA_DONE_CNT_EN
        done_model++;
`endif
        check({nm, "_yv_clr"}, y_valid, 0);
        check({nm, "_rdy_back"}, x_ready, 1);
        check({nm, "_done"}, done_cnt, done_model);
    endtask

    initial begin
        vecs[0] = '{coef: {8'd4, 8'd3, 8'd2, 8'd1}, x: {8'd1, 8'd1, 8'd1, 8'd1}, y: 10, nm: "basic"};
        vecs[1] = '{coef: {4{8'h80}}, x: {4{8'h80}}, y: 65536, nm: "max_neg"};
        vecs[2] = '{coef: {8'd0, 8'd0, 8'd0, 8'd5}, x: {8'd0, 8'd0, 8'd0, 8'hFF}, y: -5, nm: "neg_one"};
        vecs[3] = '{coef: {8'd4, 8'd3, 8'd2, 8'd1}, x: {8'hFB, 8'h04, 8'hFD, 8'h02}, y: -12, nm: "mixed"};
        vecs[4] = '{coef: {8'h80, 8'h7F, 8'h80, 8'h7F}, x: {8'h80, 8'h80, 8'h7F, 8'h7F}, y: 1, nm: "extremes"};
        vecs[5] = '{coef: {4{8'hFF}}, x: {4{8'h7F}}, y: -508, nm: "minus_ones"};

        Reset = 1'b1; coef_load = 1'b0; coef_in = '0; x_valid = 1'b0; x_in = '0; y_ready = 1'b1;
        repeat (3) step();
        Reset = 1'b0;
        check("rst_x_ready", x_ready, 0);
        check("rst_y_valid", y_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_lut_we", lut_we, 0);
        check("rst_y_out", y_out, 0);
        check("rst_lut_addr", lut_addr, 0);
        check("rst_lut_din", lut_din, 0);
        check("rst_done", done_cnt, 0);

        // Detailed first fill: every write cycle is inspected.
        coef_in = {8'd4, 8'd3, 8'd2, 8'd1};
        coef_load = 1'b1;
        step();
        coef_load = 1'b0;
        check("fill_busy", busy, 1);
        check("fill_x_ready", x_ready, 0);
        for (int a = 0; a < 16; a++) begin
            check($sformatf("fill_we_%0d", a), lut_we, 1);
            check($sformatf("fill_addr_%0d", a), lut_addr, a);
            check($sformatf("fill_din_%0d", a), lut_din, subset(coef_in, a));
            step();
        end
        check("fill_end_we", lut_we, 0);
        check("fill_end_busy", busy, 0);
        check("fill_end_rdy", x_ready, 1);
        check("lut_addr5", ram[5], 4);
        check("lut_addr15", ram[15], 10);

        for (int v = 0; v < 6; v++) begin
            load_coef(vecs[v].coef, vecs[v].nm);
            send_x(vecs[v].x, vecs[v].y, vecs[v].nm, 0);
            finish_out(vecs[v].nm);
        end

        // Backpressure: result must hold while y_ready is low.
        load_coef({8'd4, 8'd3, 8'd2, 8'd1}, "bp");
        y_ready = 1'b0;
        send_x({4{8'd1}}, 10, "bp", 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_y_valid", y_valid, 1);
            check("bp_y_hold", y_out, 10);
            check("bp_x_ready", x_ready, 0);
        end
        finish_out("bp");

        // coef_load during COMPUTE is dropped; the old LUT is used.
        coef_in = {4{8'hFF}};
        send_x({4{8'd1}}, 10, "cl_compute", 3);
        finish_out("cl_compute");

        // coef_load together with x_valid in IDLE: the fill wins.
        coef_in = {4{8'd2}};
        x_in = {4{8'd7}};
        coef_load = 1'b1;
        x_valid = 1'b1;
        #1;
        check("both_x_ready", x_ready, 0);
        step();
        coef_load = 1'b0;
        x_valid = 1'b0;
        check("both_fill_we", lut_we, 1);
        check("both_fill_addr", lut_addr, 0);
        for (int n = 0; n < 40 && !x_ready; n++) step();
        check("both_fill_done", x_ready, 1);
        send_x({8'd4, 8'd3, 8'd2, 8'd1}, 20, "both_new_lut", 0);
        finish_out("both_new_lut");

        // Reset in the middle of COMPUTE.
        x_in = {4{8'd1}};
        x_valid = 1'b1;
        step();
        x_valid = 1'b0;
        repeat (3) step();
        check("mid_busy_pre", busy, 1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        done_model = 0;
        check("mid_x_ready", x_ready, 0);
        check("mid_y_valid", y_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_lut_we", lut_we, 0);
        check("mid_y_out", y_out, 0);
        check("mid_lut_addr", lut_addr, 0);
        check("mid_lut_din", lut_din, 0);
        check("mid_done", done_cnt, 0);
        x_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_empty_rdy", x_ready, 0);
            check("mid_empty_busy", busy, 0);
        end
        x_valid = 1'b0;
        load_coef({8'd4, 8'd3, 8'd2, 8'd1}, "recover");
        send_x({4{8'd1}}, 10, "recover", 0);
        finish_out("recover");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
